// File: rtl/gpr.sv
// General-purpose register: synchronous active-low clear, load enable and a
// combinational output enable. Define GPR_TRISTATE_OUT_EN to float data_out when disabled.
module gpr #(
    parameter int unsigned       WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clk,
    input  logic             clr,
    input  logic             wa,
    input  logic             oa
);

    logic [WIDTH-1:0] store;

    // Clear wins over load on the same edge; otherwise hold.
    always_ff @(posedge clk) begin
        if (!clr) begin
            store <= RESET_VALUE;
        end else if (wa) begin
            store <= data_in;
        end
    end

    // Output enable is purely combinational so bus hand-off needs no clock.
`ifdef GPR_TRISTATE_OUT_EN
    assign data_out = oa ? store : {WIDTH{1'bz}};
`else
    assign data_out = oa ? store : {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_gpr.sv
// Directed self-checking bench for gpr at WIDTH=8, RESET_VALUE=0.
module tb_gpr;

    localparam int unsigned WIDTH = 8;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] data_in;
    logic             clk;
    logic             clr;
    logic             wa;
    logic             oa;

    int checks;
    int failures;

    logic [WIDTH-1:0] dis_val;

    gpr #(.WIDTH(WIDTH), .RESET_VALUE(8'h00)) dut (
        .data_out (data_out),
        .data_in  (data_in),
        .clk      (clk),
        .clr      (clr),
        .wa       (wa),
        .oa       (oa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, observe 1ns after the rising edge.
    task automatic edge_drive(input logic c, input logic w, input logic o, input logic [WIDTH-1:0] d);
        @(negedge clk);
        clr = c; wa = w; oa = o; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        edge_drive(1'b0, 1'b0, 1'b1, 8'hA5);
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_clear got=%h exp=%h", data_out, 8'h00);
        end
        oa = 1'b0;
        #1;
        checks++;
        if (data_out !== dis_val) begin
            failures++;
            $display("FAIL reset_oa_off got=%h exp=%h", data_out, dis_val);
        end
    endtask

    task automatic test_load;
        edge_drive(1'b1, 1'b1, 1'b1, 8'h55);
        checks++;
        if (data_out !== 8'h55) begin
            failures++;
            $display("FAIL load_55 got=%h exp=%h", data_out, 8'h55);
        end
        for (int i = 0; i < 2; i++) begin
            edge_drive(1'b1, 1'b0, 1'b1, 8'hAA);
            checks++;
            if (data_out !== 8'h55) begin
                failures++;
                $display("FAIL load_hold%0d got=%h exp=%h", i, data_out, 8'h55);
            end
        end
    endtask

    task automatic test_output_enable;
        @(negedge clk);
        oa = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h55) begin
            failures++;
            $display("FAIL oe_on1 got=%h exp=%h", data_out, 8'h55);
        end
        oa = 1'b0;
        #1;
        checks++;
        if (data_out !== dis_val) begin
            failures++;
            $display("FAIL oe_off got=%h exp=%h", data_out, dis_val);
        end
        oa = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h55) begin
            failures++;
            $display("FAIL oe_on2 got=%h exp=%h", data_out, 8'h55);
        end
    endtask

    task automatic test_priority;
        edge_drive(1'b0, 1'b1, 1'b1, 8'hFF);
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("FAIL prio_clr got=%h exp=%h", data_out, 8'h00);
        end
        edge_drive(1'b1, 1'b1, 1'b1, 8'h12);
        checks++;
        if (data_out !== 8'h12) begin
            failures++;
            $display("FAIL prio_reload got=%h exp=%h", data_out, 8'h12);
        end
    endtask

    task automatic test_hidden_write;
        edge_drive(1'b1, 1'b1, 1'b0, 8'h3C);
        checks++;
        if (data_out !== dis_val) begin
            failures++;
            $display("FAIL hidden_off got=%h exp=%h", data_out, dis_val);
        end
        wa = 1'b0;
        oa = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h3C) begin
            failures++;
            $display("FAIL hidden_on got=%h exp=%h", data_out, 8'h3C);
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] vals [3];
        vals[0] = 8'h01; vals[1] = 8'h82; vals[2] = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            edge_drive(1'b1, 1'b1, 1'b1, vals[i]);
            checks++;
            if (data_out !== vals[i]) begin
                failures++;
                $display("FAIL b2b%0d got=%h exp=%h", i, data_out, vals[i]);
            end
        end
    endtask

    task automatic test_async_clr;
        edge_drive(1'b1, 1'b1, 1'b1, 8'h55);
        wa = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        #2;
        checks++;
        if (data_out !== 8'h55) begin
            failures++;
            $display("FAIL async_during got=%h exp=%h", data_out, 8'h55);
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== 8'h55) begin
            failures++;
            $display("FAIL async_after got=%h exp=%h", data_out, 8'h55);
        end
    endtask

    task automatic test_between_edges;
        @(negedge clk);
        data_in = 8'h99;
        wa = 1'b1;
        #2;
        wa = 1'b0;
        data_in = 8'h66;
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== 8'h55) begin
            failures++;
            $display("FAIL between_edges got=%h exp=%h", data_out, 8'h55);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
`ifdef GPR_TRISTATE_OUT_EN
        dis_val = 8'hzz;
`else
        dis_val = 8'h00;
`endif
        clr = 1'b1; wa = 1'b0; oa = 1'b0; data_in = '0;
        test_reset();
        test_load();
        test_output_enable();
        test_priority();
        test_hidden_write();
        test_back_to_back();
        test_async_clr();
        test_between_edges();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
